ram_chunk_cache: RTL and testbench
==================================

Name: ram_chunk_cache

Overview:
- Direct-mapped, write-back, write-allocate chunk cache between the CPU load/store port and the DDR3 RAM controller.
- Serves 32-bit word accesses with byte masks from CHUNK_COUNT resident chunks of CHUNK_SIZE bits each.
- On a miss it writes back the dirty victim as one whole chunk, then fills the line with one whole-chunk read.
- The downstream controller sees only chunk-aligned, chunk-wide transactions.

Parameters:
- CHUNK_SIZE, 1024, line width in bits (CHUNK_SIZE/8 bytes per line)
- DATA_SIZE, 32, CPU word width in bits
- MASK_SIZE, DATA_SIZE/8, CPU byte-enable width
- ADDRESS_SIZE, 28, byte address width on both sides
- CHUNK_COUNT, 4, number of lines; power of two, at least 2

Ports:
- clk  in  1  single clock for the whole block
- rst_n  in  1  synchronous reset, active low
- cpu_valid  in  1  request present
- cpu_write  in  1  1 = store, 0 = load
- cpu_address  in  ADDRESS_SIZE  byte address; bits [1:0] ignored
- cpu_mask  in  MASK_SIZE  byte enables for stores
- cpu_write_value  in  DATA_SIZE  store data
- cpu_ready  out  1  block can accept a request this cycle
- cpu_done  out  1  one-cycle pulse on completion of the accepted request
- cpu_read_value  out  DATA_SIZE  load data, valid while cpu_done=1 for a load
- cpu_error  out  1  sticky error flag
- ram_address  out  ADDRESS_SIZE  chunk-aligned byte address
- ram_write_trigger  out  1  one-cycle chunk write command
- ram_write_chunk  out  CHUNK_SIZE  chunk to write; held stable until the write completes
- ram_read_trigger  out  1  one-cycle chunk read command
- ram_read_chunk  in  CHUNK_SIZE  fill data
- ram_read_valid  in  1  one-cycle pulse; ram_read_chunk valid
- ram_ready  in  1  controller idle and accepting commands
- ram_error  in  4  controller error code; 0 = no error

Behaviour:
- Address split:
  - offset = low log2(CHUNK_SIZE/8) bits; word index = offset[.. :2]
  - line index = next log2(CHUNK_COUNT) bits; tag = remaining upper bits
  - Defaults: word = [6:2], index = [8:7], tag = [27:9].
- Per line: valid bit, dirty bit, tag, CHUNK_SIZE data.
- rst_n=0 at a clock edge:
  - All valid and dirty bits clear; state = IDLE.
  - cpu_ready=1; cpu_done=0; cpu_error=0; cpu_read_value=0.
  - ram_write_trigger=0; ram_read_trigger=0; ram_address=0.
  - Line data and tags are not reset.
- Reset mid-operation aborts the operation. Dirty data is lost. Any in-flight controller transaction is ignored; a ram_read_valid arriving after reset does not modify lines.
- cpu_ready=1 only in IDLE and only while cpu_error=0.
- A request is accepted when cpu_valid && cpu_ready. The block latches address, mask, data and direction on acceptance.
- States and transitions:
  - IDLE: on accept, compare tags.
    - Hit: complete next cycle. cpu_done=1 one cycle after acceptance; cpu_ready=1 again in that same cycle (back-to-back hits sustain 1 access/cycle).
    - Miss with dirty victim: go to WB_ISSUE.
    - Miss, clean or invalid: go to FILL_ISSUE.
  - WB_ISSUE:
    - Wait for ram_ready=1, then pulse ram_write_trigger for 1 cycle.
    - ram_address = {victim tag, index, zero offset}; ram_write_chunk = victim data.
    - Go to WB_WAIT.
  - WB_WAIT: ignore ram_ready in the first cycle after the trigger. The write is complete at the first later cycle with ram_ready=1. Then clear dirty and go to FILL_ISSUE.
  - FILL_ISSUE:
    - Wait for ram_ready=1, then pulse ram_read_trigger for 1 cycle.
    - ram_address = {request tag, index, zero offset}.
    - Go to FILL_WAIT.
  - FILL_WAIT: on ram_read_valid, load the line, set valid, set tag, and go to RESPOND.
  - RESPOND: perform the access as a hit. cpu_done=1 for 1 cycle; go to IDLE.
- Loads:
  - cpu_read_value = selected word, registered.
  - It holds its value until the next completion.
- Stores:
  - Byte-lane merge: lane b is written only where mask[b]=1.
  - Sets dirty, even when mask=0.
  - In RESPOND the merge applies to the freshly filled data.
- Never more than one controller command is outstanding. Triggers are never asserted while ram_ready=0.
- Error handling:
  - ram_error != 0 sampled in any non-IDLE state sets cpu_error.
  - The block returns to IDLE without cpu_done, and the line is left unchanged.
  - cpu_error is cleared only by reset; cpu_ready stays 0 while it is set.
- cpu_valid held during a miss is not re-accepted; the request is latched once.

Optional Feature:
- Macro: RAM_CHUNK_CACHE_STATS_EN.
- Defined: adds outputs stat_hits[31:0], stat_misses[31:0] and stat_writebacks[31:0].
  - Increment on a hit completion, on a miss detection and on a WB_ISSUE trigger, respectively.
  - Counters saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then load 0x0000100 -> miss: one ram_read_trigger with ram_address=0x0000100, no write trigger. Model returns chunk word k = k -> cpu_done with cpu_read_value=0x00000000. A load of 0x0000104 then hits with value 1, cpu_done exactly 1 cycle after accept.
- Store 0xAABBCCDD, mask 4'b0101, to 0x0000108 (resident, word 2, old value 2) -> cpu_done next cycle, no ram traffic. A load of 0x0000108 returns 0x00BB00DD.
- Load 0x0000300 (same index 2, different tag) after the dirty store -> ram_write_trigger first with address 0x0000100 and word 2 of the chunk = 0x00BB00DD. Then, only after ram_ready recovers, ram_read_trigger at 0x0000300.
- Hold ram_ready=0 for 20 cycles during FILL_ISSUE -> no trigger until ram_ready=1, then exactly one pulse.
- ram_error=4'h1 during FILL_WAIT -> cpu_error=1, cpu_ready=0, no cpu_done. Assert rst_n=0 for 1 cycle -> cpu_error=0, cpu_ready=1, the next access to the previously resident 0x0000100 misses.
- With RAM_CHUNK_CACHE_STATS_EN defined, run the sequence above -> stat_hits, stat_misses and stat_writebacks match the counts of hits, misses and write-backs executed.

Source files
------------

// File: rtl/ram_chunk_cache.sv
// rtl/ram_chunk_cache.sv - direct-mapped write-back chunk cache between CPU port and DDR3 controller
// Optional hit/miss/write-back counters are enabled with `define RAM_CHUNK_CACHE_STATS_EN.
module ram_chunk_cache #(
  parameter int CHUNK_SIZE   = 1024,
  parameter int DATA_SIZE    = 32,
  parameter int MASK_SIZE    = DATA_SIZE / 8,
  parameter int ADDRESS_SIZE = 28,
  parameter int CHUNK_COUNT  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_valid,
  input  logic                    cpu_write,
  input  logic [ADDRESS_SIZE-1:0] cpu_address,
  input  logic [MASK_SIZE-1:0]    cpu_mask,
  input  logic [DATA_SIZE-1:0]    cpu_write_value,
  output logic                    cpu_ready,
  output logic                    cpu_done,
  output logic [DATA_SIZE-1:0]    cpu_read_value,
  output logic                    cpu_error,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic                    ram_write_trigger,
  output logic [CHUNK_SIZE-1:0]   ram_write_chunk,
  output logic                    ram_read_trigger,
  input  logic [CHUNK_SIZE-1:0]   ram_read_chunk,
  input  logic                    ram_read_valid,
  input  logic                    ram_ready,
  input  logic [3:0]              ram_error
`ifdef RAM_CHUNK_CACHE_STATS_EN
  ,
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [31:0]             stat_writebacks
`endif
);

  localparam int OFFSET_W = $clog2(CHUNK_SIZE / 8);
  localparam int WORD_W   = OFFSET_W - 2;
  localparam int INDEX_W  = $clog2(CHUNK_COUNT);
  localparam int TAG_W    = ADDRESS_SIZE - OFFSET_W - INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    WB_ISSUE,
    WB_WAIT,
    FILL_ISSUE,
    FILL_WAIT,
    RESPOND
  } state_t;

  state_t state, state_next;

  logic [TAG_W-1:0]      tag_mem   [CHUNK_COUNT];
  logic [CHUNK_SIZE-1:0] line_data [CHUNK_COUNT];
  logic [CHUNK_COUNT-1:0] line_valid;
  logic [CHUNK_COUNT-1:0] line_dirty;

  logic [TAG_W-1:0]     req_tag;
  logic [INDEX_W-1:0]   req_index;
  logic [WORD_W-1:0]    req_word;
  logic [MASK_SIZE-1:0] req_mask;
  logic [DATA_SIZE-1:0] req_data;
  logic                 req_write;

  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] cpu_index;
  logic [WORD_W-1:0]  cpu_word;
  logic               hit;
  logic               victim_dirty;
  logic               accept;
  logic               ram_fault;
  logic               do_access;
  logic               fill_load;
  logic               wb_done;
  logic               wb_first;

  logic [INDEX_W-1:0]   acc_index;
  logic [WORD_W-1:0]    acc_word;
  logic [MASK_SIZE-1:0] acc_mask;
  logic [DATA_SIZE-1:0] acc_data;
  logic                 acc_write;

  assign cpu_tag      = cpu_address[ADDRESS_SIZE-1 -: TAG_W];
  assign cpu_index    = cpu_address[OFFSET_W +: INDEX_W];
  assign cpu_word     = cpu_address[2 +: WORD_W];
  assign hit          = line_valid[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
  assign victim_dirty = line_valid[cpu_index] && line_dirty[cpu_index];

  assign cpu_ready = (state == IDLE) && !cpu_error;
  assign accept    = cpu_valid && cpu_ready;
  assign ram_fault = (state != IDLE) && (ram_error != 4'd0);

  // Hits complete from IDLE using the live request; misses complete in RESPOND from the latched one.
  assign do_access = (accept && hit) || ((state == RESPOND) && !ram_fault);
  assign acc_index = (state == RESPOND) ? req_index : cpu_index;
  assign acc_word  = (state == RESPOND) ? req_word  : cpu_word;
  assign acc_mask  = (state == RESPOND) ? req_mask  : cpu_mask;
  assign acc_data  = (state == RESPOND) ? req_data  : cpu_write_value;
  assign acc_write = (state == RESPOND) ? req_write : cpu_write;

  assign fill_load = (state == FILL_WAIT) && (state_next == RESPOND);
  assign wb_done   = (state == WB_WAIT) && (state_next == FILL_ISSUE);

  assign ram_write_chunk = line_data[req_index];

  always_comb begin
    state_next        = state;
    ram_write_trigger = 1'b0;
    ram_read_trigger  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && !hit) state_next = victim_dirty ? WB_ISSUE : FILL_ISSUE;
      end
      WB_ISSUE: begin
        if (ram_ready) begin
          ram_write_trigger = 1'b1;
          state_next        = WB_WAIT;
        end
      end
      WB_WAIT: begin
        // The controller may still show ready in the cycle right after the trigger.
        if (!wb_first && ram_ready) state_next = FILL_ISSUE;
      end
      FILL_ISSUE: begin
        if (ram_ready) begin
          ram_read_trigger = 1'b1;
          state_next       = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (ram_read_valid) state_next = RESPOND;
      end
      RESPOND: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (ram_fault) begin
      state_next        = IDLE;
      ram_write_trigger = 1'b0;
      ram_read_trigger  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      line_valid     <= '0;
      line_dirty     <= '0;
      cpu_done       <= 1'b0;
      cpu_error      <= 1'b0;
      cpu_read_value <= '0;
      ram_address    <= '0;
      wb_first       <= 1'b0;
      req_tag        <= '0;
      req_index      <= '0;
      req_word       <= '0;
      req_mask       <= '0;
      req_data       <= '0;
      req_write      <= 1'b0;
    end else begin
      state    <= state_next;
      cpu_done <= do_access;
      wb_first <= ram_write_trigger;
      if (ram_fault) cpu_error <= 1'b1;
      if (accept) begin
        req_tag   <= cpu_tag;
        req_index <= cpu_index;
        req_word  <= cpu_word;
        req_mask  <= cpu_mask;
        req_data  <= cpu_write_value;
        req_write <= cpu_write;
        if (!hit) begin
          ram_address <= victim_dirty ? {tag_mem[cpu_index], cpu_index, {OFFSET_W{1'b0}}}
                                      : {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
        end
      end
      if (wb_done) begin
        line_dirty[req_index] <= 1'b0;
        ram_address           <= {req_tag, req_index, {OFFSET_W{1'b0}}};
      end
      if (fill_load) begin
        line_valid[req_index] <= 1'b1;
        line_dirty[req_index] <= 1'b0;
      end
      if (do_access) begin
        if (acc_write) line_dirty[acc_index] <= 1'b1;
        else cpu_read_value <= line_data[acc_index][int'(acc_word) * DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Line contents and tags are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill_load) begin
        line_data[req_index] <= ram_read_chunk;
        tag_mem[req_index]   <= req_tag;
      end
      if (do_access && acc_write) begin
        for (int b = 0; b < MASK_SIZE; b++) begin
          if (acc_mask[b]) begin
            line_data[acc_index][int'(acc_word) * DATA_SIZE + b * 8 +: 8] <= acc_data[b * 8 +: 8];
          end
        end
      end
    end
  end

`ifdef RAM_CHUNK_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (accept && hit && (stat_hits != 32'hFFFFFFFF)) stat_hits <= stat_hits + 32'd1;
      if (accept && !hit && (stat_misses != 32'hFFFFFFFF)) stat_misses <= stat_misses + 32'd1;
      if (ram_write_trigger && (stat_writebacks != 32'hFFFFFFFF)) begin
        stat_writebacks <= stat_writebacks + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_chunk_cache.sv
// tb/tb_ram_chunk_cache.sv - directed self-checking bench for ram_chunk_cache
module tb_ram_chunk_cache;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_valid;
  logic          cpu_write;
  logic [27:0]   cpu_address;
  logic [3:0]    cpu_mask;
  logic [31:0]   cpu_write_value;
  logic          cpu_ready;
  logic          cpu_done;
  logic [31:0]   cpu_read_value;
  logic          cpu_error;
  logic [27:0]   ram_address;
  logic          ram_write_trigger;
  logic [1023:0] ram_write_chunk;
  logic          ram_read_trigger;
  logic [1023:0] ram_read_chunk;
  logic          ram_read_valid;
  logic          ram_ready;
  logic [3:0]    ram_error;
`ifdef RAM_CHUNK_CACHE_STATS_EN
  logic [31:0]   stat_hits;
  logic [31:0]   stat_misses;
  logic [31:0]   stat_writebacks;
`endif

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int viol   = 0;

  ram_chunk_cache dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cpu_valid        (cpu_valid),
    .cpu_write        (cpu_write),
    .cpu_address      (cpu_address),
    .cpu_mask         (cpu_mask),
    .cpu_write_value  (cpu_write_value),
    .cpu_ready        (cpu_ready),
    .cpu_done         (cpu_done),
    .cpu_read_value   (cpu_read_value),
    .cpu_error        (cpu_error),
    .ram_address      (ram_address),
    .ram_write_trigger(ram_write_trigger),
    .ram_write_chunk  (ram_write_chunk),
    .ram_read_trigger (ram_read_trigger),
    .ram_read_chunk   (ram_read_chunk),
    .ram_read_valid   (ram_read_valid),
    .ram_ready        (ram_ready),
    .ram_error        (ram_error)
`ifdef RAM_CHUNK_CACHE_STATS_EN
    ,
    .stat_hits        (stat_hits),
    .stat_misses      (stat_misses),
    .stat_writebacks  (stat_writebacks)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_read_trigger) begin
      rd_cnt = rd_cnt + 1;
      if (!ram_ready) viol = viol + 1;
    end
    if (ram_write_trigger) begin
      wr_cnt = wr_cnt + 1;
      if (!ram_ready) viol = viol + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic req(input logic wr, input logic [27:0] a, input logic [3:0] m, input logic [31:0] d);
    cpu_valid       = 1'b1;
    cpu_write       = wr;
    cpu_address     = a;
    cpu_mask        = m;
    cpu_write_value = d;
    tick();
    cpu_valid = 1'b0;
  endtask

  function automatic logic [1023:0] pattern(input logic [31:0] base);
    logic [1023:0] p;
    for (int k = 0; k < 32; k++) p[k*32 +: 32] = base + k;
    return p;
  endfunction

  task automatic fill(input logic [31:0] base);
    ram_read_chunk = pattern(base);
    ram_read_valid = 1'b1;
    tick();
    ram_read_valid = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    cpu_valid       = 1'b0;
    cpu_write       = 1'b0;
    cpu_address     = '0;
    cpu_mask        = '0;
    cpu_write_value = '0;
    ram_read_chunk  = '0;
    ram_read_valid  = 1'b0;
    ram_ready       = 1'b1;
    ram_error       = 4'h0;
    tick();
    tick();
    chk("reset_ready", cpu_ready, 1);
    chk("reset_done", cpu_done, 0);
    chk("reset_error", cpu_error, 0);
    chk("reset_read_value", cpu_read_value, 0);
    chk("reset_ram_address", ram_address, 0);
    chk("reset_triggers", {ram_write_trigger, ram_read_trigger}, 0);
    rst_n = 1'b1;
    tick();

    // Cold miss with the controller busy for 20 cycles
    ram_ready = 1'b0;
    req(1'b0, 28'h0000100, 4'h0, 32'h0);
    chk("fill_held_off", ram_read_trigger, 0);
    chk("busy_not_ready", cpu_ready, 0);
    repeat (20) tick();
    chk("fill_no_trigger_20", rd_cnt, 0);
    ram_ready = 1'b1;
    #1;
    chk("fill_trigger", ram_read_trigger, 1);
    chk("fill_address", ram_address, 32'h0000100);
    chk("fill_no_write", ram_write_trigger, 0);
    tick();
    ram_ready = 1'b0;
    chk("fill_single_pulse", rd_cnt, 1);
    tick();
    tick();
    ram_ready = 1'b1;
    fill(32'h0);
    tick();
    chk("miss_done", cpu_done, 1);
    chk("miss_value", cpu_read_value, 32'h0);
    chk("miss_ram_cmds", rd_cnt * 16 + wr_cnt, 16);

    // Hits
    req(1'b0, 28'h0000104, 4'h0, 32'h0);
    chk("hit_done", cpu_done, 1);
    chk("hit_value", cpu_read_value, 32'h1);
    tick();
    chk("hit_done_pulse", cpu_done, 0);
    req(1'b1, 28'h0000108, 4'b0101, 32'hAABBCCDD);
    chk("store_done", cpu_done, 1);
    req(1'b0, 28'h0000108, 4'h0, 32'h0);
    chk("store_merge", cpu_read_value, 32'h00BB00DD);
    chk("hits_no_ram", rd_cnt + wr_cnt, 1);

    // Conflict miss on index 2 with a dirty victim
    req(1'b0, 28'h0000300, 4'h0, 32'h0);
    chk("wb_trigger", ram_write_trigger, 1);
    chk("wb_address", ram_address, 32'h0000100);
    chk("wb_word2", ram_write_chunk[95:64], 32'h00BB00DD);
    chk("wb_no_read", ram_read_trigger, 0);
    tick();
    tick();
    ram_ready = 1'b0;
    #1;
    chk("wb_busy_no_read", ram_read_trigger, 0);
    repeat (3) tick();
    ram_ready = 1'b1;
    #1;
    chk("wb_complete_first", ram_read_trigger, 0);
    tick();
    chk("fill2_trigger", ram_read_trigger, 1);
    chk("fill2_address", ram_address, 32'h0000300);
    chk("wb_count", wr_cnt, 1);
    tick();
`ifdef RAM_CHUNK_CACHE_STATS_EN
    chk("stat_hits", stat_hits, 3);
    chk("stat_misses", stat_misses, 2);
    chk("stat_writebacks", stat_writebacks, 1);
`endif

    // Controller error during the fill
    ram_error = 4'h1;
    tick();
    ram_error = 4'h0;
    chk("err_flag", cpu_error, 1);
    chk("err_not_ready", cpu_ready, 0);
    chk("err_no_done", cpu_done, 0);
    req(1'b0, 28'h0000104, 4'h0, 32'h0);
    tick();
    chk("err_blocks_request", cpu_done, 0);
    chk("err_sticky", cpu_error, 1);

    // Reset clears the error and invalidates every line
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_error_clear", cpu_error, 0);
    chk("rst_ready", cpu_ready, 1);
`ifdef RAM_CHUNK_CACHE_STATS_EN
    chk("rst_stat_hits", stat_hits, 0);
`endif
    req(1'b0, 28'h0000100, 4'h0, 32'h0);
    chk("remiss_trigger", ram_read_trigger, 1);
    chk("remiss_address", ram_address, 32'h0000100);
    chk("remiss_no_wb", ram_write_trigger, 0);
    tick();
    fill(32'h5000);
    tick();
    chk("remiss_done", cpu_done, 1);
    chk("remiss_value", cpu_read_value, 32'h5000);
`ifdef RAM_CHUNK_CACHE_STATS_EN
    chk("final_stat_misses", stat_misses, 1);
    chk("final_stat_writebacks", stat_writebacks, 0);
`endif
    chk("trigger_while_busy", viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
